ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the keyboard over the same PS2_CLK/PS2_DATA pins the keyboard decoder listens on. It sits beside the decoder in the top level. The top level turns the *_oe outputs into open-drain drivers: line = oe ? 0 : 'bz. While `busy` is high, the decoder treats bus activity as host traffic.

---
 rtl/ps2_host_tx.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device command transmitter.
//
// Sends one command byte to a PS/2 device using the host request sequence:
// inhibit the clock, pull data low (start bit), release the clock, then put
// each following bit on the data line after every device-generated falling
// clock edge, and finally sample the device ACK on the 11th falling edge.
//
// Valid/ready: a byte is taken when tx_valid && tx_ready on a rising clk
// edge; tx_ready is high only while the transmitter is idle, and a tx_valid
// seen at any other time is dropped (never queued).
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   tx_valid      request to send tx_data
//   tx_data[7:0]  command byte
//   tx_ready      high only in IDLE
//   ps2_clk_in    PS2_CLK pin as read back
//   ps2_data_in   PS2_DATA pin as read back
//   ps2_clk_oe    1 = pull PS2_CLK low (open drain, driven by top level)
//   ps2_data_oe   1 = pull PS2_DATA low
//   busy          high in every state except IDLE
//   tx_done       one-cycle pulse when the device acknowledged the frame
//   tx_error      one-cycle pulse on NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 500,
  parameter int FILTER_LEN     = 8,
  parameter int START_TIMEOUT  = 1500000,
  parameter int FRAME_TIMEOUT  = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  // One shared phase counter serves INHIBIT, REQ and WAIT_CLK, so it is
  // sized for the largest of the three limits.
  localparam int CNT_MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > START_TIMEOUT) ? CNT_MAX_A : START_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int FRM_W     = $clog2(FRAME_TIMEOUT + 1);
  localparam int FLT_W     = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_WAIT_CLK,
    S_SEND,
    S_ACK,
    S_WAIT_HIGH,
    S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             tx_done_q, tx_done_d;
  logic             tx_error_q, tx_error_d;

  logic             clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic             data_s1_q, data_s1_d, data_s2_q, data_s2_d;
  logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic             clk_filt_q, clk_filt_d;
  logic             clk_filt_prev_q, clk_filt_prev_d;

  logic             fall;
  logic             frame_expired;
  logic [CNT_W-1:0] cnt_inc;
  logic [FRM_W-1:0] frame_inc;

  // Input conditioning: 2-FF synchronizers, then a run-length filter on the
  // clock. The filter only flips after FILTER_LEN consecutive samples that
  // disagree with the current filtered value, so short glitches reset the
  // run and never reach the state machine.
  always_comb begin
    clk_s1_d        = ps2_clk_in;
    clk_s2_d        = clk_s1_q;
    data_s1_d       = ps2_data_in;
    data_s2_d       = data_s1_q;
    clk_filt_d      = clk_filt_q;
    filt_cnt_d      = '0;
    clk_filt_prev_d = clk_filt_q;
    if (clk_s2_q != clk_filt_q) begin
      if (filt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  assign fall = clk_filt_prev_q & ~clk_filt_q;

  // Saturating increments: counters hold at their maximum instead of wrapping.
  assign cnt_inc       = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
  assign frame_inc     = (frame_cnt_q == FRM_W'(FRAME_TIMEOUT)) ? frame_cnt_q : frame_cnt_q + 1'b1;
  assign frame_expired = (frame_cnt_q >= FRM_W'(FRAME_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    tx_done_d   = 1'b0;
    tx_error_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          // {stop, odd parity, data}; shifted out LSB first.
          shift_d     = {1'b1, ~^tx_data, tx_data};
          bit_idx_d   = '0;
          cnt_d       = '0;
          frame_cnt_d = '0;
          clk_oe_d    = 1'b1;
          state_d     = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_REQ: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          // Release the clock; data stays low as the start bit.
          cnt_d    = '0;
          clk_oe_d = 1'b0;
          state_d  = S_WAIT_CLK;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_CLK: begin
        if (fall) begin
          data_oe_d   = ~shift_q[0];
          shift_d     = {1'b0, shift_q[9:1]};
          bit_idx_d   = 4'd1;
          frame_cnt_d = '0;
          state_d     = S_SEND;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          state_d    = S_ERROR;
          clk_oe_d   = 1'b0;
          data_oe_d  = 1'b0;
          tx_error_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_SEND: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          state_d    = S_ERROR;
          data_oe_d  = 1'b0;
          tx_error_d = 1'b1;
        end else if (fall) begin
          // bit_idx_q counts falls already served; fall 10 puts out the stop
          // bit (a one, so data is released) and the ACK clock comes next.
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[9:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd9) begin
            state_d = S_ACK;
          end
        end
      end

      S_ACK: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          state_d    = S_ERROR;
          data_oe_d  = 1'b0;
          tx_error_d = 1'b1;
        end else if (fall) begin
          if (!data_s2_q) begin
            state_d = S_WAIT_HIGH;
          end else begin
            state_d    = S_ERROR;
            data_oe_d  = 1'b0;
            tx_error_d = 1'b1;
          end
        end
      end

      S_WAIT_HIGH: begin
        frame_cnt_d = frame_inc;
        if (frame_expired) begin
          state_d    = S_ERROR;
          data_oe_d  = 1'b0;
          tx_error_d = 1'b1;
        end else if (clk_filt_q) begin
          tx_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end

      S_ERROR: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      frame_cnt_q     <= '0;
      shift_q         <= '0;
      bit_idx_q       <= '0;
      clk_oe_q        <= 1'b0;
      data_oe_q       <= 1'b0;
      tx_done_q       <= 1'b0;
      tx_error_q      <= 1'b0;
      clk_s1_q        <= 1'b1;
      clk_s2_q        <= 1'b1;
      data_s1_q       <= 1'b1;
      data_s2_q       <= 1'b1;
      filt_cnt_q      <= '0;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      shift_q         <= shift_d;
      bit_idx_q       <= bit_idx_d;
      clk_oe_q        <= clk_oe_d;
      data_oe_q       <= data_oe_d;
      tx_done_q       <= tx_done_d;
      tx_error_q      <= tx_error_d;
      clk_s1_q        <= clk_s1_d;
      clk_s2_q        <= clk_s2_d;
      data_s1_q       <= data_s1_d;
      data_s2_q       <= data_s2_d;
      filt_cnt_q      <= filt_cnt_d;
      clk_filt_q      <= clk_filt_d;
      clk_filt_prev_q <= clk_filt_prev_d;
    end
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = tx_done_q;
  assign tx_error    = tx_error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device drives the clock,
// samples the data line just before each falling edge and optionally ACKs.
// Expected frames are built from the byte with plain arithmetic.
module tb_ps2_host_tx;

  localparam int INH   = 120;
  localparam int SETUP = 20;
  localparam int FLT   = 8;
  localparam int STO   = 2000;
  localparam int FTO   = 3000;
  localparam int HALF  = 40;

  logic       clk;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  // Open-drain bus: host pulls via *_oe, device via its own drive bits.
  logic dev_clk_hi;
  logic dev_data_low;
  logic ps2_clk_line;
  logic ps2_data_line;
  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk_hi;
  assign ps2_data_line = ~ps2_data_oe & ~dev_data_low;

  int checks;
  int errors;
  int done_seen;
  int err_seen;

  logic [0:0] exp_q[$];

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SETUP),
    .FILTER_LEN    (FLT),
    .START_TIMEOUT (STO),
    .FRAME_TIMEOUT (FTO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts done/error pulses and checks they never coincide.
  always @(negedge clk) begin
    if (tx_done === 1'b1) done_seen++;
    if (tx_error === 1'b1) err_seen++;
    if (tx_done === 1'b1 || tx_error === 1'b1) begin
      checks++;
      if (tx_done === 1'b1 && tx_error === 1'b1) begin
        errors++;
        $display("FAIL done_err_overlap: done=%b error=%b, required not both 1", tx_done, tx_error);
      end
    end
  end

  // Reference frame: start 0, data LSB first, odd parity, stop 1.
  task automatic build_exp(input logic [7:0] b);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(b[i]);
      ones += int'(b[i]);
    end
    exp_q.push_back((ones % 2 == 0) ? 1'b1 : 1'b0);
    exp_q.push_back(1'b1);
  endtask

  // Driver: submit a byte, time the inhibit/setup phases, then act as the
  // device for up to 11 clocks (or abort_at clocks when nonzero).
  task automatic run_frame(input logic [7:0] b, input bit ack, input bit glitch,
                           input int abort_at, input bit poke_busy,
                           output bit accepted, output int inh_n, output int setup_n,
                           output int n_samp, output logic [10:0] samp);
    samp   = '0;
    n_samp = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    accepted = (tx_ready === 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    inh_n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh_n < 10000) begin
      inh_n++;
      if (poke_busy && inh_n == 5) begin
        tx_valid = 1'b1;
        tx_data  = 8'hF4;
      end else begin
        tx_valid = 1'b0;
      end
      @(negedge clk);
    end
    tx_valid = 1'b0;
    setup_n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && setup_n < 10000) begin
      setup_n++;
      @(negedge clk);
    end
    for (int k = 1; k <= 11; k++) begin
      for (int c = 0; c < HALF; c++) begin
        if (glitch && k == 5 && c >= 10 && c < 15) dev_clk_hi = 1'b0;
        else dev_clk_hi = 1'b1;
        @(negedge clk);
      end
      dev_clk_hi = 1'b1;
      samp[k-1] = ps2_data_line;
      n_samp++;
      if (k == 11 && ack) dev_data_low = 1'b1;
      dev_clk_hi = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk_hi = 1'b1;
      if (abort_at != 0 && k == abort_at) break;
    end
    repeat (5) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_idle(output int t);
    t = 0;
    while (busy !== 1'b0 && t < 500) begin
      t++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL reset_clk_oe: got %b want 0", ps2_clk_oe); end
    checks++; if (ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_data_oe: got %b want 0", ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b want 0", tx_done); end
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL reset_tx_error: got %b want 0", tx_error); end
  endtask

  task automatic test_frame(input logic [7:0] b, input bit ack, input bit glitch, input string name);
    bit acc;
    int inh_n, setup_n, n_samp, t, d0, e0;
    logic [10:0] samp;
    logic [0:0] e;
    build_exp(b);
    d0 = done_seen;
    e0 = err_seen;
    run_frame(b, ack, glitch, 0, 0, acc, inh_n, setup_n, n_samp, samp);
    wait_idle(t);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL %s_accept: ready %b want 1", name, acc); end
    checks++; if (inh_n != INH) begin errors++; $display("FAIL %s_inhibit_len: got %0d want %0d", name, inh_n, INH); end
    checks++; if (setup_n != SETUP) begin errors++; $display("FAIL %s_setup_len: got %0d want %0d", name, setup_n, SETUP); end
    for (int i = 0; i < 11; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (samp[i] !== e[0]) begin
        errors++;
        $display("FAIL %s_bit%0d: byte %02h got %b want %b", name, i, b, samp[i], e[0]);
      end
    end
    checks++; if (done_seen - d0 != (ack ? 1 : 0)) begin errors++; $display("FAIL %s_done_count: got %0d want %0d", name, done_seen - d0, ack ? 1 : 0); end
    checks++; if (err_seen - e0 != (ack ? 0 : 1)) begin errors++; $display("FAIL %s_error_count: got %0d want %0d", name, err_seen - e0, ack ? 0 : 1); end
    checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL %s_end_idle: ready %b clk_oe %b data_oe %b want 1 0 0", name, tx_ready, ps2_clk_oe, ps2_data_oe);
    end
  endtask

  task automatic test_ack_frames;
    test_frame(8'hED, 1'b1, 1'b0, "ack_ed");
    for (int n = 0; n < 3; n++) test_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, "ack_rand");
  endtask

  task automatic test_nack;
    test_frame(8'h00, 1'b0, 1'b0, "nack_00");
  endtask

  task automatic test_glitch;
    test_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, "glitch");
  endtask

  task automatic test_start_timeout;
    int t, d0, e0;
    d0 = done_seen;
    e0 = err_seen;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    t = 0;
    while (ps2_clk_oe === 1'b1 && t < 10000) begin t++; @(negedge clk); end
    t = 0;
    while (tx_error !== 1'b1 && t < STO + 100) begin @(negedge clk); t++; end
    checks++; if (t != STO) begin errors++; $display("FAIL start_timeout_delay: got %0d want %0d", t, STO); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout_oe: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe);
    end
    wait_idle(t);
    checks++; if (err_seen - e0 != 1 || done_seen - d0 != 0) begin
      errors++;
      $display("FAIL start_timeout_pulses: err %0d done %0d want 1 0", err_seen - e0, done_seen - d0);
    end
  endtask

  task automatic test_busy_and_abort;
    bit acc;
    int inh_n, setup_n, n_samp, d0, e0;
    logic [10:0] samp;
    logic [7:0] b;
    logic [0:0] e;
    b = 8'($urandom_range(0, 255));
    if (b == 8'hF4) b = 8'h5A;
    build_exp(b);
    d0 = done_seen;
    e0 = err_seen;
    run_frame(b, 1'b1, 1'b0, 4, 1'b1, acc, inh_n, setup_n, n_samp, samp);
    checks++; if (inh_n != INH) begin errors++; $display("FAIL abort_inhibit_len: got %0d want %0d", inh_n, INH); end
    checks++; if (n_samp != 4) begin errors++; $display("FAIL abort_nsamp: got %0d want 4", n_samp); end
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (samp[i] !== e[0]) begin
        errors++;
        $display("FAIL abort_bit%0d: byte %02h got %b want %b", i, b, samp[i], e[0]);
      end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: clk_oe %b data_oe %b want 0 0", ps2_clk_oe, ps2_data_oe);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: busy %b ready %b want 0 1", busy, tx_ready); end
    checks++; if (done_seen - d0 != 0 || err_seen - e0 != 0) begin
      errors++;
      $display("FAIL abort_pulses: done %0d err %0d want 0 0", done_seen - d0, err_seen - e0);
    end
    test_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, "after_abort");
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    done_seen    = 0;
    err_seen     = 0;
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_hi   = 1'b1;
    dev_data_low = 1'b0;
    test_reset();
    test_ack_frames();
    test_nack();
    test_start_timeout();
    test_glitch();
    test_busy_and_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
